interp_sched: RTL and testbench

INTERP_SCHED -- requirements
Module: interp_sched

---
 rtl/interp_sched.sv | 197 +++++++++++++++++++
 tb/tb_interp_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_sched.sv
// Linear-interpolation scheduler: slides a two-sample window along the sample
// stream, issues one core operation per query, and returns results in order.
module interp_sched #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    USER_WIDTH = 1,
  parameter int                    FIFO_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] ERROR_CODE = 16'h8000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_x,
  input  logic [DATA_WIDTH-1:0]         s_y,
  input  logic                          s_last,
  input  logic                          q_valid,
  output logic                          q_ready,
  input  logic [DATA_WIDTH-1:0]         q_x,
  input  logic [USER_WIDTH-1:0]         q_user,
  input  logic                          q_last,
  output logic                          core_vld,
  output logic [DATA_WIDTH-1:0]         core_x_sub_x0,
  output logic [DATA_WIDTH-1:0]         core_x_sub_x1,
  output logic [DATA_WIDTH-1:0]         core_y1_sub_y0,
  output logic [DATA_WIDTH-1:0]         core_y0,
  output logic [USER_WIDTH-1:0]         core_user,
  input  logic                          res_vld,
  input  logic [DATA_WIDTH-1:0]         res_y,
  input  logic [USER_WIDTH-1:0]         res_user,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_y,
  output logic [USER_WIDTH-1:0]         m_user,
  output logic                          seq_err,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_credit
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FILL0 = 2'd0, FILL1 = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] x0, y0, x1, y1;
  logic                  single, last_seen, active;
  logic [CW-1:0]         credit;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [DATA_WIDTH+USER_WIDTH-1:0] mem [FIFO_DEPTH];

  logic s_hs, q_hs, pop, full, wr_en, overflow;
  logic q_lt_x0, q_ge_x1, q_oor, q_adv, s_gt_x0, s_gt_x1;

  assign q_lt_x0 = $signed(q_x) < $signed(x0);
  assign q_ge_x1 = $signed(q_x) >= $signed(x1);
  assign s_gt_x0 = $signed(s_x) > $signed(x0);
  assign s_gt_x1 = $signed(s_x) > $signed(x1);
  assign q_oor   = single || q_lt_x0 || (q_ge_x1 && last_seen);
  assign q_adv   = !q_oor && q_ge_x1;

  // All streams use valid/ready: a transfer happens on a rising edge where both
  // are high; ready may depend combinationally on the partner's valid and data.
  always_comb begin
    s_ready = 1'b0;
    q_ready = 1'b0;
    case (state)
      FILL0, FILL1, DRAIN: s_ready = active;
      RUN: if (q_valid) begin
        if (q_adv) s_ready = active;
        else       q_ready = active && (credit != '0);
      end
      default: ;
    endcase
  end

  assign s_hs = s_valid && s_ready;
  assign q_hs = q_valid && q_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL0: if (s_hs) state_nxt = s_last ? RUN : FILL1;
      FILL1: if (s_hs && (s_gt_x0 || s_last)) state_nxt = RUN;
      RUN:   if (q_hs && q_last) state_nxt = (last_seen || single) ? FILL0 : DRAIN;
      DRAIN: if (s_hs && s_last) state_nxt = FILL0;
      default: state_nxt = FILL0;
    endcase
  end

  // Ports stay not-ready until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL0;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0;
      single    <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        FILL0: if (s_hs) begin
          x0 <= s_x; y0 <= s_y;
          if (s_last) single <= 1'b1;
        end
        FILL1: if (s_hs) begin
          if (s_gt_x0) begin
            x1 <= s_x; y1 <= s_y;
            last_seen <= s_last;
          end else if (s_last) begin
            single <= 1'b1;
          end
        end
        RUN: begin
          if (s_hs) begin
            if (s_gt_x1) begin
              x0 <= x1; y0 <= y1;
              x1 <= s_x; y1 <= s_y;
            end
            last_seen <= s_last;
          end
          if (q_hs && q_last) begin
            single    <= 1'b0;
            last_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_vld       <= 1'b0;
      core_x_sub_x0  <= '0;
      core_x_sub_x1  <= '0;
      core_y1_sub_y0 <= '0;
      core_y0        <= '0;
      core_user      <= '0;
    end else begin
      core_vld <= q_hs;
      if (q_hs) begin
        core_user <= q_user;
        if (q_oor) begin
          // Zero slope over a unit span makes the core return ERROR_CODE unchanged.
          core_x_sub_x0  <= '0;
          core_x_sub_x1  <= DATA_WIDTH'(1);
          core_y1_sub_y0 <= '0;
          core_y0        <= ERROR_CODE;
        end else begin
          core_x_sub_x0  <= q_x - x0;
          core_x_sub_x1  <= x1 - q_x;
          core_y1_sub_y0 <= y1 - y0;
          core_y0        <= y0;
        end
      end
    end
  end

  assign pop      = m_valid && m_ready;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en    = res_vld && (!full || pop);
  assign overflow = res_vld && full && !pop;
  assign m_valid  = (wr_ptr != rd_ptr);
  assign {m_y, m_user} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {res_y, res_user};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      credit  <= CW'(FIFO_DEPTH);
      seq_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (q_hs && !pop)      credit <= credit - CW'(1);
      else if (!q_hs && pop) credit <= credit + CW'(1);
      if (overflow || (s_hs && state == FILL1 && !s_gt_x0) ||
          (s_hs && state == RUN && !s_gt_x1))
        seq_err <= 1'b1;
    end
  end

  assign dbg_state  = state;
  assign dbg_credit = credit;

endmodule

// File: tb/tb_interp_sched.sv
// Directed bench for interp_sched: vector table of two-sample frames plus
// hand-written multi-cycle sequences, with a behavioural core in the loop.
module tb_interp_sched;
  localparam int DW = 16;
  localparam int UW = 1;
  localparam int FD = 4;

  logic clk, rst_n;
  logic s_valid, s_ready, s_last;
  logic [DW-1:0] s_x, s_y;
  logic q_valid, q_ready, q_last;
  logic [DW-1:0] q_x;
  logic [UW-1:0] q_user;
  logic core_vld;
  logic [DW-1:0] core_x_sub_x0, core_x_sub_x1, core_y1_sub_y0, core_y0;
  logic [UW-1:0] core_user;
  logic res_vld;
  logic [DW-1:0] res_y;
  logic [UW-1:0] res_user;
  logic m_valid, m_ready;
  logic [DW-1:0] m_y;
  logic [UW-1:0] m_user;
  logic seq_err;
  logic [1:0] dbg_state;
  logic [2:0] dbg_credit;

  interp_sched #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_DEPTH(FD), .ERROR_CODE(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_last(s_last),
    .q_valid(q_valid), .q_ready(q_ready), .q_x(q_x), .q_user(q_user), .q_last(q_last),
    .core_vld(core_vld), .core_x_sub_x0(core_x_sub_x0), .core_x_sub_x1(core_x_sub_x1),
    .core_y1_sub_y0(core_y1_sub_y0), .core_y0(core_y0), .core_user(core_user),
    .res_vld(res_vld), .res_y(res_y), .res_user(res_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_user(m_user),
    .seq_err(seq_err), .dbg_state(dbg_state), .dbg_credit(dbg_credit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int iss_cnt = 0;
  int s_cnt = 0;
  bit saw_drain = 0;
  logic [DW*4+UW-1:0] exp_q[$];
  logic [DW+UW-1:0]   res_q[$];
  logic [DW*4+UW-1:0] e_core;
  logic [DW+UW-1:0]   e_res;

  typedef struct {
    logic [DW-1:0] sx0, sy0, sx1, sy1, qx;
    logic [UW-1:0] usr;
    logic [DW-1:0] e_xs0, e_xs1, e_dy, e_y0;
  } vec_t;
  vec_t vec [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [DW-1:0] xs0, xs1, dy, y0, input logic [UW-1:0] u);
    logic [DW-1:0] s;
    s = y0 + xs0;
    exp_q.push_back({u, xs0, xs1, dy, y0});
    res_q.push_back({s, u});
  endfunction

  // driver tasks
  task automatic send_sample(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic last);
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      s_valid = 1'b1; s_x = x; s_y = y; s_last = last;
      #1;
      if (s_ready) begin
        @(posedge clk);
        done = 1;
      end
    end
    #1 s_valid = 1'b0;
    if (done) s_cnt++;
    check("sample_accepted", 64'(done), 64'd1);
  endtask

  task automatic send_query(input logic [DW-1:0] x, input logic [UW-1:0] u, input logic last);
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      q_valid = 1'b1; q_x = x; q_user = u; q_last = last;
      #1;
      if (q_ready) begin
        @(posedge clk);
        done = 1;
      end
    end
    #1 q_valid = 1'b0;
    check("query_accepted", 64'(done), 64'd1);
  endtask

  // behavioural core: result = y0 + (x - x0) is enough to track order and data
  initial begin
    res_vld = 1'b0; res_y = '0; res_user = '0;
    forever begin
      @(posedge clk);
      #1;
      res_vld  = core_vld;
      res_y    = core_y0 + core_x_sub_x0;
      res_user = core_user;
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (core_vld) begin
      iss_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL core_unexpected: got %0h expected none", {core_user, core_x_sub_x0, core_x_sub_x1, core_y1_sub_y0, core_y0});
      end else begin
        e_core = exp_q.pop_front();
        if ({core_user, core_x_sub_x0, core_x_sub_x1, core_y1_sub_y0, core_y0} !== e_core) begin
          errors++;
          $display("FAIL core_issue: got %0h expected %0h", {core_user, core_x_sub_x0, core_x_sub_x1, core_y1_sub_y0, core_y0}, e_core);
        end
      end
    end
    if (m_valid && m_ready) begin
      checks++;
      if (res_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got %0h expected none", {m_y, m_user});
      end else begin
        e_res = res_q.pop_front();
        if ({m_y, m_user} !== e_res) begin
          errors++;
          $display("FAIL result: got %0h expected %0h", {m_y, m_user}, e_res);
        end
      end
    end
    if (dbg_state == 2'd3) saw_drain = 1;
  end

  task automatic settle_and_check(input string name);
    repeat (5) @(negedge clk);
    check({name, "_state"}, 64'(dbg_state), 64'd0);
    check({name, "_queues"}, 64'(exp_q.size() + res_q.size()), 64'd0);
  endtask

  initial begin
    int s0, i0;
    vec[0] = '{16'd0,    16'd100,  16'd10,   16'd200,  16'd3,    1'b1, 16'd3,    16'd7,    16'd100,  16'd100};
    vec[1] = '{16'hFFEC, 16'h0032, 16'h0014, 16'hFFCE, 16'hFFFB, 1'b0, 16'h000F, 16'h0019, 16'hFF9C, 16'h0032};
    vec[2] = '{16'd5,    16'd7,    16'd9,    16'd1,    16'd5,    1'b1, 16'd0,    16'd4,    16'hFFFA, 16'd7};
    vec[3] = '{16'd5,    16'd7,    16'd9,    16'd1,    16'd9,    1'b0, 16'd0,    16'd1,    16'd0,    16'h8000};
    vec[4] = '{16'd5,    16'd7,    16'd9,    16'd1,    16'd4,    1'b1, 16'd0,    16'd1,    16'd0,    16'h8000};
    vec[5] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'd0,    1'b0, 16'h8000, 16'h7FFF, 16'h0001, 16'h7FFF};
    vec[6] = '{16'd100,  16'd0,    16'd200,  16'd1000, 16'd199,  1'b1, 16'd99,   16'd1,    16'h03E8, 16'd0};

    rst_n = 1'b0;
    s_valid = 0; s_x = '0; s_y = '0; s_last = 0;
    q_valid = 0; q_x = '0; q_user = '0; q_last = 0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 0);
    check("rst_q_ready", 64'(q_ready), 0);
    check("rst_core_vld", 64'(core_vld), 0);
    check("rst_core_data", {core_x_sub_x0, core_x_sub_x1, core_y1_sub_y0, core_y0}, 0);
    check("rst_m_valid", 64'(m_valid), 0);
    check("rst_seq_err", 64'(seq_err), 0);
    check("rst_credit", 64'(dbg_credit), 64'(FD));
    check("rst_state", 64'(dbg_state), 0);
    rst_n = 1'b1;
    #1 check("release_s_ready_low", 64'(s_ready), 0);
    @(posedge clk); #1;
    check("run_s_ready", 64'(s_ready), 1);
    check("run_q_ready", 64'(q_ready), 0);

    for (int i = 0; i < 7; i++) begin
      push_exp(vec[i].e_xs0, vec[i].e_xs1, vec[i].e_dy, vec[i].e_y0, vec[i].usr);
      fork
        begin
          send_sample(vec[i].sx0, vec[i].sy0, 1'b0);
          send_sample(vec[i].sx1, vec[i].sy1, 1'b1);
        end
        send_query(vec[i].qx, vec[i].usr, 1'b1);
      join
      settle_and_check($sformatf("vec%0d", i));
    end

    // interpolation across a window advance
    push_exp(16'd8, 16'd8, 16'd256, 16'd0, 1'b0);
    push_exp(16'd0, 16'd16, 16'hFF00, 16'd256, 1'b1);
    push_exp(16'd8, 16'd8, 16'hFF00, 16'd256, 1'b0);
    fork
      begin send_sample(16'd0, 16'd0, 0); send_sample(16'd16, 16'd256, 0); send_sample(16'd32, 16'd0, 1); end
      begin send_query(16'd8, 1'b0, 0); send_query(16'd16, 1'b1, 0); send_query(16'd24, 1'b0, 1); end
    join
    settle_and_check("interp");

    // out-of-range on both sides
    s0 = s_cnt;
    push_exp(16'd0, 16'd1, 16'd0, 16'h8000, 1'b0);
    push_exp(16'd0, 16'd1, 16'd0, 16'h8000, 1'b1);
    fork
      begin send_sample(16'd10, 16'd5, 0); send_sample(16'd20, 16'd9, 1); end
      begin send_query(16'd5, 1'b0, 0); send_query(16'd25, 1'b1, 1); end
    join
    settle_and_check("oor");
    check("oor_samples", 64'(s_cnt - s0), 64'd2);

    // backpressure with a full result FIFO
    @(posedge clk); #1 m_ready = 1'b0;
    for (int q = 1; q <= 6; q++) push_exp(16'(q), 16'(100 - q), 16'd100, 16'd0, 1'b0);
    i0 = iss_cnt;
    fork
      begin send_sample(16'd0, 16'd0, 0); send_sample(16'd100, 16'd100, 1); end
      begin for (int q = 1; q <= 6; q++) send_query(16'(q), 1'b0, q == 6); end
      begin
        repeat (30) @(negedge clk);
        #2;
        check("bp_issued4", 64'(iss_cnt - i0), 64'd4);
        check("bp_q_ready", 64'(q_ready), 0);
        check("bp_credit0", 64'(dbg_credit), 0);
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        repeat (10) @(negedge clk);
        #2 check("bp_issued5", 64'(iss_cnt - i0), 64'd5);
        @(posedge clk); #1 m_ready = 1'b1;
      end
    join
    settle_and_check("bp");

    // early frame end through DRAIN
    saw_drain = 0;
    s0 = s_cnt;
    push_exp(16'd5, 16'd5, 16'd1, 16'd0, 1'b1);
    fork
      begin for (int k = 0; k < 8; k++) send_sample(16'(k * 10), 16'(k), k == 7); end
      send_query(16'd5, 1'b1, 1'b1);
    join
    settle_and_check("drain");
    check("drain_seen", 64'(saw_drain), 1);
    check("drain_samples", 64'(s_cnt - s0), 64'd8);

    // non-ascending samples
    check("seq_err_clean", 64'(seq_err), 0);
    push_exp(16'd2, 16'd3, 16'd6, 16'd1, 1'b0);
    fork
      begin
        send_sample(16'd4, 16'd1, 0); send_sample(16'd4, 16'd2, 0);
        send_sample(16'd3, 16'd3, 0); send_sample(16'd9, 16'd7, 1);
      end
      send_query(16'd6, 1'b0, 1'b1);
    join
    settle_and_check("badseq");
    check("seq_err_set", 64'(seq_err), 1);

    // reset with results queued
    @(posedge clk); #1 m_ready = 1'b0;
    for (int q = 1; q <= 3; q++) push_exp(16'(q), 16'(100 - q), 16'd100, 16'd0, 1'b0);
    fork
      begin send_sample(16'd0, 16'd0, 0); send_sample(16'd100, 16'd100, 1); end
      begin for (int q = 1; q <= 3; q++) send_query(16'(q), 1'b0, q == 3); end
    join
    repeat (4) @(negedge clk);
    check("pre_rst_m_valid", 64'(m_valid), 1);
    check("pre_rst_credit", 64'(dbg_credit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 0);
    check("mid_rst_q_ready", 64'(q_ready), 0);
    check("mid_rst_s_ready", 64'(s_ready), 0);
    res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_credit", 64'(dbg_credit), 64'(FD));
    check("post_rst_state", 64'(dbg_state), 0);
    check("post_rst_seq_err", 64'(seq_err), 0);
    check("post_rst_m_valid", 64'(m_valid), 0);
    m_ready = 1'b1;

    push_exp(vec[0].e_xs0, vec[0].e_xs1, vec[0].e_dy, vec[0].e_y0, vec[0].usr);
    fork
      begin send_sample(vec[0].sx0, vec[0].sy0, 0); send_sample(vec[0].sx1, vec[0].sy1, 1); end
      send_query(vec[0].qx, vec[0].usr, 1'b1);
    join
    settle_and_check("post_rst_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
